// File: rtl/stream_demux_1to2.sv
// Registered 1-to-2 stream demultiplexer: each accepted word is steered into one of two
// independent FIFOs, each drained by its own valid/ready handshake. Optional DEMUX_COUNT_EN adds per-output pop counters.
//
// state      | meaning
// -----------+-----------------------------------------------
// ST_EMPTY   | occupancy 0, Validk low
// ST_PARTIAL | 0 < occupancy < DEPTH, accepts and offers words
// ST_FULL    | occupancy == DEPTH, pushes refused
module stream_demux_1to2 #(
  parameter int WIDTH = 16,
  parameter int DEPTH = 2
) (
  input  logic             Clock,
  input  logic             Reset_n,
  input  logic [WIDTH-1:0] Operand,
  input  logic             SelectorInput,
  input  logic             InValid,
  output logic             InReady,
  output logic [WIDTH-1:0] Result1,
  output logic [WIDTH-1:0] Result2,
  output logic             Valid1,
  output logic             Valid2,
  input  logic             Ready1,
  input  logic             Ready2
`ifdef DEMUX_COUNT_EN
  ,
  output logic [7:0]       Count1,
  output logic [7:0]       Count2
`endif
);

  localparam int AW = $clog2(DEPTH);
  localparam int CW = AW + 1;

  typedef enum logic [1:0] {ST_EMPTY, ST_PARTIAL, ST_FULL} fifo_state_t;

  logic [WIDTH-1:0] mem [2][DEPTH];
  logic [AW-1:0]    wr_ptr [2];
  logic [AW-1:0]    rd_ptr [2];
  logic [CW-1:0]    occ [2];
  fifo_state_t      state [2];
  logic [1:0]       full;
  logic [1:0]       valid;
  logic [1:0]       push;
  logic [1:0]       pop;
  logic [1:0]       out_ready;
  logic             accept;

  // State is a pure function of occupancy, so it never disagrees with the counters.
  always_comb begin
    for (int k = 0; k < 2; k++) begin
      state[k] = ST_EMPTY;
      if (occ[k] == CW'(DEPTH))
        state[k] = ST_FULL;
      else if (occ[k] != '0)
        state[k] = ST_PARTIAL;
    end
  end

  always_comb begin
    full  = '0;
    valid = '0;
    for (int k = 0; k < 2; k++) begin
      full[k]  = (state[k] == ST_FULL);
      valid[k] = (state[k] != ST_EMPTY);
    end
  end

  assign out_ready = {Ready2, Ready1};
  assign InReady   = SelectorInput ? ~full[1] : ~full[0];
  assign accept    = InValid & InReady;
  assign push      = {accept & SelectorInput, accept & ~SelectorInput};
  assign pop       = valid & out_ready;

  always_ff @(posedge Clock) begin
    if (!Reset_n) begin
      for (int k = 0; k < 2; k++) begin
        wr_ptr[k] <= '0;
        rd_ptr[k] <= '0;
        occ[k]    <= '0;
        for (int i = 0; i < DEPTH; i++)
          mem[k][i] <= '0;
      end
    end else begin
      for (int k = 0; k < 2; k++) begin
        if (push[k]) begin
          mem[k][wr_ptr[k]] <= Operand;
          wr_ptr[k]         <= wr_ptr[k] + AW'(1);
        end
        if (pop[k])
          rd_ptr[k] <= rd_ptr[k] + AW'(1);
        case ({push[k], pop[k]})
          2'b10:   occ[k] <= occ[k] + CW'(1);
          2'b01:   occ[k] <= occ[k] - CW'(1);
          default: occ[k] <= occ[k];
        endcase
      end
    end
  end

  assign Valid1  = valid[0];
  assign Valid2  = valid[1];
  assign Result1 = mem[0][rd_ptr[0]];
  assign Result2 = mem[1][rd_ptr[1]];

`ifdef DEMUX_COUNT_EN
  logic [7:0] pop_cnt [2];

  always_ff @(posedge Clock) begin
    if (!Reset_n) begin
      pop_cnt[0] <= '0;
      pop_cnt[1] <= '0;
    end else begin
      for (int k = 0; k < 2; k++)
        if (pop[k])
          pop_cnt[k] <= pop_cnt[k] + 8'd1;
    end
  end

  assign Count1 = pop_cnt[0];
  assign Count2 = pop_cnt[1];
`endif

endmodule
